// File: rtl/kitchen_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kitchen_link_pkg
//  Purpose  : Shared constants and types for the kitchen link arbiter:
//             arbitration mode codes, default idle byte, FSM state encoding
//             and a clog2 helper that never returns zero.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package kitchen_link_pkg;

   // Arbitration mode codes on arb_mode_i; code 3 behaves like ARB_PRIO.
   localparam logic [1:0] ARB_PRIO  = 2'd0;
   localparam logic [1:0] ARB_RR    = 2'd1;
   localparam logic [1:0] ARB_FORCE = 2'd2;

   localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } link_state_e;

   // Index width for a set of n items; a single item still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : kitchen_link_pkg
`default_nettype wire

// File: rtl/kitchen_link_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kitchen_link_fifo
//  Purpose  : Synchronous single-clock FIFO holding queued command bytes for
//             one arbiter channel.
//  Ports    : clock_i, reset_i        clock, sync active-high reset
//             push_i, data_i          write request and byte
//             pop_i                   remove head entry
//             flush_i                 discard all entries (beats push/pop)
//             full_o, empty_o         occupancy flags
//             head_o                  oldest entry (valid when !empty_o)
//  Revision : 1.0  initial release
// ============================================================================
module kitchen_link_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [DATA_W-1:0] head_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // when the address fields are equal.
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic push_ok;
   logic pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // No simultaneous pop-and-push bypass at full: a full FIFO refuses pushes.
   assign push_ok = push_i && !full_o && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; contents are only visible through the pointers.
   always_ff @(posedge clock_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule : kitchen_link_fifo
`default_nettype wire

// File: rtl/kitchen_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : kitchen_link_arbiter
//  Purpose  : N-channel command arbiter in front of the UART transmitter.
//             Each channel queues bytes in its own FIFO; one byte at a time
//             is granted (fixed priority / round-robin / forced) and held on
//             uart_bits_o until the UART acknowledges it. Also captures the
//             returned game-state byte with an update strobe and counter.
//  Ports    : clock_i, reset_i        clock, sync active-high reset
//             ch_valid_i/ch_bits_i    per-channel push request and byte
//             ch_ready_o              per-channel FIFO not full
//             arb_mode_i, force_ch_i  arbitration mode and forced channel
//             flush_i                 per-channel FIFO clear
//             uart_bits_o             byte to UART (IDLE_BYTE when idle)
//             uart_ready_i            UART byte-complete pulse
//             in_flight_o, grant_ch_o byte being presented and its owner
//             rx_bits_i, rx_valid_i   received byte from UART
//             fb_bits_o, fb_strobe_o, fb_count_o   feedback capture
//             overflow_o              sticky push-while-full flags
//  Revision : 1.0  initial release
// ============================================================================
module kitchen_link_arbiter
   import kitchen_link_pkg::*;
#(
   parameter int                NUM_CH     = 2,
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] IDLE_BYTE  = DATA_W'(DEFAULT_IDLE_BYTE),
   parameter int                CH_W       = clog2_min1(NUM_CH)
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [NUM_CH-1:0]        ch_valid_i,
   input  logic [NUM_CH*DATA_W-1:0] ch_bits_i,
   output logic [NUM_CH-1:0]        ch_ready_o,
   input  logic [1:0]               arb_mode_i,
   input  logic [CH_W-1:0]          force_ch_i,
   input  logic [NUM_CH-1:0]        flush_i,
   output logic [DATA_W-1:0]        uart_bits_o,
   input  logic                     uart_ready_i,
   output logic                     in_flight_o,
   output logic [CH_W-1:0]          grant_ch_o,
   input  logic [DATA_W-1:0]        rx_bits_i,
   input  logic                     rx_valid_i,
   output logic [DATA_W-1:0]        fb_bits_o,
   output logic                     fb_strobe_o,
   output logic [15:0]              fb_count_o,
   output logic [NUM_CH-1:0]        overflow_o
);

   // ------------------------------------------------------------------
   // Per-channel FIFOs and overflow flags
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0] full_w;
   logic [NUM_CH-1:0] empty_w;
   logic [NUM_CH-1:0] pop_w;
   logic [DATA_W-1:0] head_w [NUM_CH];
   logic [NUM_CH-1:0] overflow_q;

   link_state_e       state_q, state_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic              gnt_flushed_q, gnt_flushed_d;
   logic              ack_w;

   // Acknowledge is only meaningful while a byte is on the wire.
   assign ack_w = (state_q == ST_SEND) && uart_ready_i;

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         // A flush of the granted channel mid-send leaves the byte on the
         // wire but must not pop whatever was pushed after the flush.
         assign pop_w[i] = ack_w && (grant_q == CH_W'(i)) &&
                           !gnt_flushed_q && !flush_i[i];

         kitchen_link_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .push_i  (ch_valid_i[i]),
            .data_i  (ch_bits_i[i*DATA_W +: DATA_W]),
            .pop_i   (pop_w[i]),
            .flush_i (flush_i[i]),
            .full_o  (full_w[i]),
            .empty_o (empty_w[i]),
            .head_o  (head_w[i])
         );

         always_ff @(posedge clock_i) begin
            if (reset_i || flush_i[i]) begin
               overflow_q[i] <= 1'b0;
            end else if (ch_valid_i[i] && full_w[i]) begin
               overflow_q[i] <= 1'b1;
            end
         end
      end
   endgenerate

   assign ch_ready_o = ~full_w;
   assign overflow_o = overflow_q;

   // ------------------------------------------------------------------
   // Channel selection
   // ------------------------------------------------------------------
   // A channel being flushed this cycle is not offered for grant, so a
   // byte that is about to be discarded never reaches the UART.
   logic [NUM_CH-1:0] elig_w;
   logic              found_w;
   logic [CH_W-1:0]   sel_w;

   assign elig_w = ~empty_w & ~flush_i;

   always_comb begin
      int idx;
      found_w = 1'b0;
      sel_w   = '0;
      idx     = 0;
      case (arb_mode_i)
         ARB_RR: begin
            for (int k = 0; k < NUM_CH; k++) begin
               idx = (int'(rr_ptr_q) + k) % NUM_CH;
               if (!found_w && elig_w[idx]) begin
                  found_w = 1'b1;
                  sel_w   = CH_W'(idx);
               end
            end
         end
         ARB_FORCE: begin
            if ((int'(force_ch_i) < NUM_CH) && elig_w[force_ch_i]) begin
               found_w = 1'b1;
               sel_w   = force_ch_i;
            end
         end
         default: begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
               if (elig_w[k]) begin
                  found_w = 1'b1;
                  sel_w   = CH_W'(k);
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      out_d         = out_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      gnt_flushed_d = gnt_flushed_q;
      case (state_q)
         ST_IDLE: begin
            if (found_w) begin
               state_d       = ST_SEND;
               out_d         = head_w[sel_w];
               grant_d       = sel_w;
               gnt_flushed_d = 1'b0;
               if (arb_mode_i == ARB_RR) begin
                  rr_ptr_d = (sel_w == CH_W'(NUM_CH - 1)) ? '0 : sel_w + 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (flush_i[grant_q]) gnt_flushed_d = 1'b1;
            if (uart_ready_i) begin
               // Returning through IDLE guarantees one idle byte between
               // consecutive grants.
               state_d       = ST_IDLE;
               out_d         = IDLE_BYTE;
               gnt_flushed_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            out_d   = IDLE_BYTE;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         out_q         <= IDLE_BYTE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         gnt_flushed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_q         <= out_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         gnt_flushed_q <= gnt_flushed_d;
      end
   end

   assign uart_bits_o = out_q;
   assign in_flight_o = (state_q == ST_SEND);
   assign grant_ch_o  = grant_q;

   // ------------------------------------------------------------------
   // Feedback capture (independent of the transmit path)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] fb_bits_q;
   logic              fb_strobe_q;
   logic [15:0]       fb_count_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fb_bits_q   <= '0;
         fb_strobe_q <= 1'b0;
         fb_count_q  <= '0;
      end else begin
         fb_strobe_q <= rx_valid_i;
         if (rx_valid_i) begin
            fb_bits_q  <= rx_bits_i;
            fb_count_q <= fb_count_q + 16'd1;
         end
      end
   end

   assign fb_bits_o   = fb_bits_q;
   assign fb_strobe_o = fb_strobe_q;
   assign fb_count_o  = fb_count_q;

endmodule : kitchen_link_arbiter
`default_nettype wire

// File: tb/tb_kitchen_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kitchen_link_arbiter
//  Purpose  : Self-checking bench for kitchen_link_arbiter. Expected output
//             bytes and owners are queued as stimulus is driven and popped
//             as the DUT presents each byte.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kitchen_link_arbiter;

   localparam int NUM_CH     = 2;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*DATA_W-1:0] ch_bits;
   logic [NUM_CH-1:0]        ch_ready;
   logic [1:0]               arb_mode;
   logic [0:0]               force_ch;
   logic [NUM_CH-1:0]        flush;
   logic [DATA_W-1:0]        uart_bits;
   logic                     uart_ready;
   logic                     in_flight;
   logic [0:0]               grant_ch;
   logic [DATA_W-1:0]        rx_bits;
   logic                     rx_valid;
   logic [DATA_W-1:0]        fb_bits;
   logic                     fb_strobe;
   logic [15:0]              fb_count;
   logic [NUM_CH-1:0]        overflow;

   always #5 clk = ~clk;

   kitchen_link_arbiter #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock_i      (clk),
      .reset_i      (reset),
      .ch_valid_i   (ch_valid),
      .ch_bits_i    (ch_bits),
      .ch_ready_o   (ch_ready),
      .arb_mode_i   (arb_mode),
      .force_ch_i   (force_ch),
      .flush_i      (flush),
      .uart_bits_o  (uart_bits),
      .uart_ready_i (uart_ready),
      .in_flight_o  (in_flight),
      .grant_ch_o   (grant_ch),
      .rx_bits_i    (rx_bits),
      .rx_valid_i   (rx_valid),
      .fb_bits_o    (fb_bits),
      .fb_strobe_o  (fb_strobe),
      .fb_count_o   (fb_count),
      .overflow_o   (overflow)
   );

   typedef struct {
      logic [7:0] b;
      logic [0:0] ch;
   } exp_t;

   exp_t sb[$];
   exp_t rx_sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add_exp(input logic [7:0] b, input logic [0:0] ch);
      exp_t e;
      e.b  = b;
      e.ch = ch;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1; ch_valid = '0; ch_bits = '0; arb_mode = 2'd0;
      force_ch = '0; flush = '0; uart_ready = 1'b0; rx_bits = '0; rx_valid = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Waits (bounded) for a presented byte, records it, then acknowledges it.
   task automatic ack_one(output logic [7:0] b, output logic [0:0] g, output bit to);
      int n;
      to = 1'b1; n = 0; b = '0; g = '0;
      while (to && n < 50) begin
         @(negedge clk);
         if (in_flight) begin
            to = 1'b0; b = uart_bits; g = grant_ch;
         end
         n++;
      end
      if (!to) begin
         @(negedge clk);
         uart_ready = 1'b1;
         @(negedge clk);
         uart_ready = 1'b0;
      end
   endtask

   // Same-cycle ch0=A1/ch1=B1, then ch0=A2 on the next cycle.
   task automatic drive_abc();
      ch_valid = 2'b11; ch_bits = {8'hB1, 8'hA1};
      @(negedge clk);
      ch_valid = 2'b01; ch_bits = {8'h00, 8'hA2};
      @(negedge clk);
      ch_valid = 2'b00;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ch_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b want 11", ch_ready); end
      checks++; if (uart_bits !== 8'h00) begin errors++; $display("FAIL reset_uart: got %h want 00", uart_bits); end
      checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL reset_inflight: got %b want 0", in_flight); end
      checks++; if (grant_ch !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_ch); end
      checks++; if (fb_bits !== 8'h00 || fb_strobe !== 1'b0 || fb_count !== 16'd0)
         begin errors++; $display("FAIL reset_fb: got %h/%b/%0d want 00/0/0", fb_bits, fb_strobe, fb_count); end
      checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", overflow); end
   endtask

   task automatic test_single();
      exp_t e;
      do_reset();
      add_exp(8'h12, 1'b0);
      ch_valid = 2'b01; ch_bits = {8'h00, 8'h12};
      @(negedge clk);
      ch_valid = 2'b00;
      checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL single_early: in_flight %b want 0", in_flight); end
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (uart_bits !== e.b) begin errors++; $display("FAIL single_latency: got %h want %h", uart_bits, e.b); end
      checks++; if (in_flight !== 1'b1 || grant_ch !== e.ch)
         begin errors++; $display("FAIL single_grant: in_flight %b grant %b want 1 %b", in_flight, grant_ch, e.ch); end
      repeat (10) @(negedge clk);
      checks++; if (uart_bits !== e.b) begin errors++; $display("FAIL single_hold: got %h want %h", uart_bits, e.b); end
      uart_ready = 1'b1;
      @(negedge clk);
      uart_ready = 1'b0;
      checks++; if (uart_bits !== 8'h00 || in_flight !== 1'b0)
         begin errors++; $display("FAIL single_ack: got %h/%b want 00/0", uart_bits, in_flight); end
      repeat (3) @(negedge clk);
      checks++; if (in_flight !== 1'b0 || ch_ready !== 2'b11)
         begin errors++; $display("FAIL single_empty: in_flight %b ready %b want 0 11", in_flight, ch_ready); end
   endtask

   task automatic test_prio();
      exp_t e; logic [7:0] b; logic [0:0] g; bit to;
      do_reset();
      arb_mode = 2'd0;
      add_exp(8'hA1, 1'b0); add_exp(8'hA2, 1'b0); add_exp(8'hB1, 1'b1);
      drive_abc();
      for (int i = 0; i < 3; i++) begin
         ack_one(b, g, to);
         e = sb.pop_front();
         checks++;
         if (to) begin errors++; $display("FAIL prio_timeout: byte %0d not presented, want %h", i, e.b); end
         else if (b !== e.b || g !== e.ch) begin
            errors++; $display("FAIL prio_order: byte %0d got %h/ch%0d want %h/ch%0d", i, b, g, e.b, e.ch);
         end
      end
   endtask

   task automatic test_rr();
      exp_t e; logic [7:0] b; logic [0:0] g; bit to;
      do_reset();
      arb_mode = 2'd1;
      add_exp(8'hA1, 1'b0); add_exp(8'hB1, 1'b1); add_exp(8'hA2, 1'b0);
      drive_abc();
      for (int i = 0; i < 3; i++) begin
         ack_one(b, g, to);
         e = sb.pop_front();
         checks++;
         if (to) begin errors++; $display("FAIL rr_timeout: byte %0d not presented, want %h", i, e.b); end
         else if (b !== e.b || g !== e.ch) begin
            errors++; $display("FAIL rr_order: byte %0d got %h/ch%0d want %h/ch%0d", i, b, g, e.b, e.ch);
         end
      end
   endtask

   task automatic test_force();
      exp_t e; logic [7:0] b; logic [0:0] g; bit to;
      do_reset();
      arb_mode = 2'd2; force_ch = 1'b1;
      add_exp(8'hD0, 1'b1);
      ch_valid = 2'b11; ch_bits = {8'hD0, 8'hC0};
      @(negedge clk);
      ch_valid = 2'b00;
      ack_one(b, g, to);
      e = sb.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL force_timeout: got nothing want %h", e.b); end
      else if (b !== e.b || g !== e.ch) begin
         errors++; $display("FAIL force_sel: got %h/ch%0d want %h/ch%0d", b, g, e.b, e.ch);
      end
      repeat (5) @(negedge clk);
      checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL force_hold: in_flight %b want 0", in_flight); end
      arb_mode = 2'd0;
      add_exp(8'hC0, 1'b0);
      ack_one(b, g, to);
      e = sb.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL force_release_timeout: got nothing want %h", e.b); end
      else if (b !== e.b || g !== e.ch) begin
         errors++; $display("FAIL force_release: got %h/ch%0d want %h/ch%0d", b, g, e.b, e.ch);
      end
   endtask

   task automatic test_overflow();
      int accepted;
      do_reset();
      // Force an empty channel so nothing drains ch0.
      arb_mode = 2'd2; force_ch = 1'b1;
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         if (ch_ready[0]) accepted++;
         ch_valid = 2'b01; ch_bits = {8'h00, 8'(8'h50 + i)};
         @(negedge clk);
      end
      ch_valid = 2'b00;
      checks++; if (accepted != FIFO_DEPTH) begin errors++; $display("FAIL ovf_accepted: got %0d want %0d", accepted, FIFO_DEPTH); end
      checks++; if (ch_ready[0] !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b want 0", ch_ready[0]); end
      checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL ovf_flag: got %b want 01", overflow); end
      flush = 2'b01;
      @(negedge clk);
      flush = 2'b00;
      checks++; if (ch_ready[0] !== 1'b1 || overflow !== 2'b00)
         begin errors++; $display("FAIL ovf_flush: ready %b ovf %b want 1 00", ch_ready[0], overflow); end
      arb_mode = 2'd0;
      repeat (4) @(negedge clk);
      checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL ovf_empty: in_flight %b want 0", in_flight); end
   endtask

   task automatic test_feedback();
      exp_t e;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         e.b = (i == 0) ? 8'h3C : 8'h81; e.ch = '0;
         rx_sb.push_back(e);
         rx_bits = e.b; rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         e = rx_sb.pop_front();
         checks++; if (fb_bits !== e.b || fb_strobe !== 1'b1)
            begin errors++; $display("FAIL fb_capture: got %h/%b want %h/1", fb_bits, fb_strobe, e.b); end
         @(negedge clk);
         checks++; if (fb_strobe !== 1'b0) begin errors++; $display("FAIL fb_strobe_len: got %b want 0", fb_strobe); end
      end
      checks++; if (fb_count !== 16'd2) begin errors++; $display("FAIL fb_count: got %0d want 2", fb_count); end
   endtask

   // Runs straight after test_feedback so feedback state is non-zero.
   task automatic test_reset_mid_send();
      int n;
      arb_mode = 2'd2; force_ch = 1'b1;
      ch_valid = 2'b11; ch_bits = {8'hE1, 8'hE0};
      @(negedge clk);
      ch_valid = 2'b00;
      n = 0;
      while (!in_flight && n < 20) begin @(negedge clk); n++; end
      checks++; if (!in_flight || grant_ch !== 1'b1)
         begin errors++; $display("FAIL mid_setup: in_flight %b grant %b want 1 1", in_flight, grant_ch); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (uart_bits !== 8'h00 || in_flight !== 1'b0 || grant_ch !== 1'b0)
         begin errors++; $display("FAIL mid_tx: got %h/%b/%b want 00/0/0", uart_bits, in_flight, grant_ch); end
      checks++; if (fb_bits !== 8'h00 || fb_count !== 16'd0 || ch_ready !== 2'b11 || overflow !== 2'b00)
         begin errors++; $display("FAIL mid_state: fb %h cnt %0d ready %b ovf %b", fb_bits, fb_count, ch_ready, overflow); end
      reset = 1'b0; arb_mode = 2'd0;
      repeat (4) @(negedge clk);
      checks++; if (in_flight !== 1'b0) begin errors++; $display("FAIL mid_dropped: in_flight %b want 0", in_flight); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_prio();
      test_rr();
      test_force();
      test_overflow();
      test_feedback();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_kitchen_link_arbiter
`default_nettype wire

// File: doc/kitchen_link_arbiter.md
Name: kitchen_link_arbiter

Overview:
- Sits between the command sources (manual panel, script engine, future sources) and the UART transmit path.
- Replaces the single switch-controlled byte mux with a parametrised N-channel arbiter.
- Each channel has its own command FIFO; the arbiter selects by fixed priority, round-robin or forced channel, and holds each byte stable until the UART acknowledges it.
- Also captures the returned game-state byte into a held register with an update strobe and a receive counter.

Parameters:
- NUM_CH, 2, number of command source channels (1..8).
- DATA_W, 8, command/feedback byte width.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- IDLE_BYTE, 8'h00, value driven on uart_bits when no command is in flight.

Ports:
- clock  in  1  single clock, same clock as the UART module.
- reset  in  1  synchronous, active-high.
- ch_valid  in  NUM_CH  per-channel push request.
- ch_bits  in  NUM_CH*DATA_W  per-channel byte; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_ready  out  NUM_CH  per-channel "FIFO not full".
- arb_mode  in  2  arbitration mode: 0 fixed priority (channel 0 highest), 1 round-robin, 2 forced, 3 reserved (treated as 0).
- force_ch  in  clog2(NUM_CH) (minimum 1)  channel serviced in forced mode.
- flush  in  NUM_CH  per-channel FIFO clear.
- uart_bits  out  DATA_W  byte presented to UART io_dataIn_bits.
- uart_ready  in  1  UART io_dataIn_ready; one-cycle pulse after a byte completes.
- in_flight  out  1  a byte is currently being presented.
- grant_ch  out  clog2(NUM_CH)  owner of the in-flight byte.
- rx_bits  in  DATA_W  UART io_dataOut_bits.
- rx_valid  in  1  UART io_dataOut_valid.
- fb_bits  out  DATA_W  last received byte, held.
- fb_strobe  out  1  one-cycle pulse when fb_bits updates.
- fb_count  out  16  received-byte counter; wraps at 16'hFFFF to 0.
- overflow  out  NUM_CH  sticky flag: a push was attempted while the FIFO was full.

Behaviour:
- Reset: all FIFOs empty; ch_ready all 1; uart_bits = IDLE_BYTE; in_flight = 0; grant_ch = 0; fb_bits = 0; fb_strobe = 0; fb_count = 0; overflow = 0; round-robin pointer = 0.
- Reset mid-transfer drops the in-flight byte and all queued bytes; no acknowledgement is expected afterwards.
- Push: occurs when ch_valid[i] && ch_ready[i]. ch_ready[i] = !full[i]; pop-and-push bypass at full is not allowed.
- Overflow: ch_valid[i] while full sets overflow[i] and discards the byte. overflow clears only on reset or flush[i].
- State machine IDLE:
  - uart_bits = IDLE_BYTE.
  - When any eligible FIFO is non-empty, choose a channel, load its head into the output register and go to SEND, with in_flight = 1 on the next cycle.
  - Latency: a push into an empty FIFO while IDLE appears on uart_bits 2 cycles later (FIFO write, then grant).
- State machine SEND:
  - uart_bits is held constant.
  - On uart_ready: pop the granted FIFO, return to IDLE and drive IDLE_BYTE for at least one cycle. Back-to-back bytes are therefore separated by one idle cycle.
  - uart_ready while IDLE is ignored.
- Eligibility:
  - Mode 0: lowest-index non-empty channel.
  - Mode 1: first non-empty channel at or after the pointer, wrapping; after a grant the pointer = granted channel + 1, modulo NUM_CH.
  - Mode 2: only force_ch; other channels keep their queued bytes.
- A change of arb_mode or force_ch during SEND does not abort the current byte; it takes effect at the next grant.
- flush[i]:
  - Empties FIFO i and clears overflow[i] on the next edge.
  - If i is the granted channel during SEND, the current byte still completes; the pop on acknowledgement is then suppressed.
  - Push and flush in the same cycle: flush wins.
- Feedback:
  - On rx_valid: fb_bits <= rx_bits, fb_strobe = 1 on the following cycle only, fb_count increments.
  - rx_valid held for k cycles counts k times; the source produces single-cycle valid.
- Feedback and transmit paths are independent, and simultaneous events on both are serviced in the same cycle.
- Width rule: the FIFO pointer is clog2(FIFO_DEPTH)+1 bits; full and empty are derived from the MSB and the equal-address comparison.

Decomposition:
- Shared package kitchen_link_pkg:
  - Arbitration mode constants ARB_PRIO=2'd0, ARB_RR=2'd1, ARB_FORCE=2'd2.
  - Default IDLE_BYTE.
  - The state encoding IDLE/SEND.
- One sub-module, kitchen_link_fifo: synchronous FIFO parametrised by DATA_W and FIFO_DEPTH, with push, pop, flush, full, empty and head outputs, instantiated NUM_CH times in a generate loop.
- Arbiter, output register and feedback capture stay in the top module.

Test Plan:
- Push 8'h12 on ch0 in mode 0 with no other traffic -> uart_bits = 8'h12 two cycles after the push and in_flight = 1. Assert uart_ready 10 cycles later -> uart_bits = 8'h00 the next cycle and ch0 is empty.
- Mode 0: ch0 queues 8'hA1,A2 and ch1 queues 8'hB1 in the same cycle, uart_ready is acknowledged each time -> output order A1, A2, B1.
- Mode 1 with the same stimulus -> output order A1, B1, A2, with grant_ch = 0, 1, 0.
- Mode 2 with force_ch = 1: ch0 holds 8'hC0 and ch1 holds 8'hD0 -> only D0 is sent and C0 remains queued. Switch to mode 0 -> C0 is sent next.
- FIFO_DEPTH = 4: push 5 bytes on ch0 with no acknowledgement -> ch_ready[0] = 0 after 4 accepted, overflow[0] = 1. Pulse flush[0] -> FIFO empty, overflow[0] = 0.
- rx_valid pulses carrying 8'h3C then 8'h81 -> fb_bits = 8'h3C, then 8'h81; fb_strobe pulses twice; fb_count = 2. Assert reset mid-SEND -> all outputs return to their reset values on the next edge.
